// File: rtl/seg_scan8.sv
// seg_scan8: eight-digit multiplexed seven-segment driver, double-buffered.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan8 #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  en_mask,
  input  logic [7:0]  dp_mask,
  output logic [6:0]  cn,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame,
  output logic        pending
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   act_data_q, act_data_d;
  logic [7:0]    act_en_q, act_en_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [7:0]    pend_en_q, pend_en_d;
  logic [7:0]    pend_dp_q, pend_dp_d;
  logic          pending_q, pending_d;
  logic          frame_q, frame_d;
  logic [6:0]    cn_q, cn_d;
  logic          dp_q, dp_d;
  logic [7:0]    an_q, an_d;
  logic          tick, boundary;
  logic [7:0]    sup;
  logic          lead;
  logic [3:0]    code;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    unique case (c)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign tick     = (pcnt_q == PW'(DIV - 1));
  assign boundary = tick && (idx_q == 3'd7);

  // Scan timing and buffer hand-over at frame boundaries.
  always_comb begin
    pcnt_d      = tick ? '0 : pcnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    act_data_d  = act_data_q;
    act_en_d    = act_en_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_en_d   = pend_en_q;
    pend_dp_d   = pend_dp_q;
    pending_d   = pending_q;
    frame_d     = boundary;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        act_data_d = data;
        act_en_d   = en_mask;
        act_dp_d   = dp_mask;
      end else if (pending_q) begin
        act_data_d = pend_data_q;
        act_en_d   = pend_en_q;
        act_dp_d   = pend_dp_q;
      end
    end else if (load) begin
      pend_data_d = data;
      pend_en_d   = en_mask;
      pend_dp_d   = dp_mask;
      pending_d   = 1'b1;
    end
  end

  // Leading-zero suppression mask over the next active set.
  always_comb begin
    sup  = '0;
    lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 7; k >= 1; k--) begin
      if (act_en_d[k]) begin
        if (lead && act_data_d[4*k +: 4] == 4'h0) sup[k] = 1'b1;
        else lead = 1'b0;
      end
    end
`endif
  end

  // Segment and anode drive for the upcoming slot, updated on tick only.
  always_comb begin
    cn_d = cn_q;
    dp_d = dp_q;
    an_d = an_q;
    code = act_data_d[4*idx_d +: 4];
    if (tick) begin
      cn_d = 7'h7F;
      dp_d = 1'b1;
      an_d = 8'hFF;
      if (act_en_d[idx_d]) begin
        dp_d = ~act_dp_d[idx_d];
        if (!sup[idx_d]) begin
          cn_d = glyph(code);
          an_d = ~(8'd1 << idx_d);
        end else if (act_dp_d[idx_d]) begin
          an_d = ~(8'd1 << idx_d);
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_en_q    <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_en_q   <= '0;
      pend_dp_q   <= '0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      cn_q        <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= 8'hFF;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_en_q    <= act_en_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_en_q   <= pend_en_d;
      pend_dp_q   <= pend_dp_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      cn_q        <= cn_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign cn      = cn_q;
  assign dp      = dp_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg_scan8.sv
// tb_seg_scan8: directed self-checking bench for seg_scan8 at DIV=4.
// Frame-aligned slot checks against a hand-built glyph table.
module tb_seg_scan8;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;
  logic [6:0]  cn;
  logic        dp;
  logic [7:0]  an;
  logic        frame;
  logic        pending;

  int checks = 0;
  int failures = 0;

  logic [6:0] gl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg_scan8 #(.DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .en_mask(en_mask), .dp_mask(dp_mask), .cn(cn), .dp(dp),
    .an(an), .frame(frame), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] e,
                         input logic [7:0] p);
    load = 1'b1;
    data = d;
    en_mask = e;
    dp_mask = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_seen", {31'd0, frame}, 32'd1);
  endtask

  // Expected {an, cn, dp} for slot k.
  function automatic logic [15:0] model(input logic [31:0] d,
      input logic [7:0] e, input logic [7:0] p, input int k);
    logic [7:0] s;
    logic       lz;
    logic [7:0] a;
    s  = '0;
    lz = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int j = 7; j >= 1; j--)
      if (e[j]) begin
        if (lz && d[4*j +: 4] == 4'h0) s[j] = 1'b1;
        else lz = 1'b0;
      end
`endif
    a = ~(8'd1 << k);
    if (!e[k]) return {8'hFF, 7'h7F, 1'b1};
    if (s[k]) return {p[k] ? a : 8'hFF, 7'h7F, ~p[k]};
    return {a, gl[d[4*k +: 4]], ~p[k]};
  endfunction

  // Call in the cycle frame is high; ends in the next frame cycle.
  task automatic check_frame(input string tag, input logic [31:0] d,
      input logic [7:0] e, input logic [7:0] p);
    logic [15:0] m;
    for (int k = 0; k < 8; k++) begin
      m = model(d, e, p, k);
      chk($sformatf("%s_an%0d", tag, k), {24'd0, an}, {24'd0, m[15:8]});
      chk($sformatf("%s_cn%0d", tag, k), {25'd0, cn}, {25'd0, m[7:1]});
      chk($sformatf("%s_dp%0d", tag, k), {31'd0, dp}, {31'd0, m[0]});
      repeat (4) @(negedge clk);
    end
    chk({tag, "_frame32"}, {31'd0, frame}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    data = '0;
    en_mask = '0;
    dp_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_cn", {25'd0, cn}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_pend", {31'd0, pending}, 32'd0);
    rst = 1'b0;

    do_load(32'h7654_3210, 8'hFF, 8'h00);
    chk("t1_pend", {31'd0, pending}, 32'd1);
    chk("t1_dark", {24'd0, an}, 32'hFF);
    wait_frame();
    chk("t1_pclr", {31'd0, pending}, 32'd0);
    check_frame("t1", 32'h7654_3210, 8'hFF, 8'h00);

    do_load(32'hFEDC_BA98, 8'h0F, 8'h04);
    chk("t2_pend", {31'd0, pending}, 32'd1);
    chk("t2_old", {25'd0, cn}, {25'd0, gl[0]});
    wait_frame();
    check_frame("t2", 32'hFEDC_BA98, 8'h0F, 8'h04);

    repeat (5) @(negedge clk);
    do_load(32'h1111_1111, 8'hFF, 8'hFF);
    chk("ab_pend", {31'd0, pending}, 32'd1);
    do_load(32'h89AB_CDEF, 8'hFF, 8'h81);
    chk("ab_pend2", {31'd0, pending}, 32'd1);
    wait_frame();
    check_frame("tb", 32'h89AB_CDEF, 8'hFF, 8'h81);

    repeat (31) @(negedge clk);
    do_load(32'h0000_0305, 8'hFF, 8'h00);
    chk("bd_frame", {31'd0, frame}, 32'd1);
    chk("bd_pend", {31'd0, pending}, 32'd0);
    check_frame("bd", 32'h0000_0305, 8'hFF, 8'h00);

    do_load(32'h0000_0000, 8'hFF, 8'h00);
    wait_frame();
    check_frame("z", 32'h0000_0000, 8'hFF, 8'h00);

    repeat (3) @(negedge clk);
    do_load(32'h2222_2222, 8'hFF, 8'hFF);
    chk("r_pend", {31'd0, pending}, 32'd1);
    rst = 1'b1;
    load = 1'b1;
    @(negedge clk);
    chk("r_an", {24'd0, an}, 32'hFF);
    chk("r_cn", {25'd0, cn}, 32'h7F);
    chk("r_pclr", {31'd0, pending}, 32'd0);
    load = 1'b0;
    rst = 1'b0;
    wait_frame();
    check_frame("rd", 32'h0, 8'h00, 8'h00);
    chk("rd_pend", {31'd0, pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan8.md
# seg_scan8

Eight-digit time-multiplexed seven-segment display driver. It sits downstream of the encoder/decoder datapath. It takes up to eight 4-bit digit codes plus per-digit enable and decimal-point masks. It scans them onto the board's shared active-low cathode bus (`cn`, `dp`) and active-low anode strobes (`an`), replacing the fixed single-digit drive (`an` = 8'b1111_1110). Display content is double-buffered, and updates take effect only at frame boundaries, so the display never tears.

## Interface
Parameters:
- `DIV`, 100000 — clock cycles per digit slot; legal range ≥ 2. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst` in 1 — asynchronous, active-high reset.
- `load` in 1 — single-cycle strobe; captures `data`, `en_mask`, `dp_mask` into the pending buffer.
- `data` in 32 — eight digit codes; nibble k (`data[4k+3:4k]`) drives digit k; codes 0–F.
- `en_mask` in 8 — bit k = 1 lights digit k.
- `dp_mask` in 8 — bit k = 1 lights the decimal point of digit k.
- `cn` out 7 — segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1 — decimal point, active-low.
- `an` out 8 — anode strobes, active-low, one-hot-low or all-high.
- `frame` out 1 — one-cycle pulse at each frame boundary.
- `pending` out 1 — 1 while a loaded value waits for a frame boundary.

## Operation
- Prescaler `pcnt` counts 0..DIV-1 and wraps. `tick` is asserted when `pcnt == DIV-1`.
- 3-bit slot index `idx` advances on `tick`: 0→1→…→7→0.
- A frame boundary is a `tick` with `idx == 7`.
- Two register sets, each holding 32+8+8 bits:
  - active — drives the display.
  - pend — holds a loaded value until the next frame boundary.
- `load` without a boundary: `data`/`en_mask`/`dp_mask` are written to pend and `pending` is set. A repeated load before the boundary overwrites pend; the last load wins.
- Boundary with `pending` = 1: pend is copied to active and `pending` is cleared.
- `load` coinciding with a boundary: the inputs go directly to active, bypassing pend, and `pending` is cleared.
- Per slot k, the outputs are registered and computed from active plus the next `idx`:
  - `an` has bit k low and all other bits high.
  - `cn` is the hex glyph of nibble k: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - `dp` = ~`dp_mask[k]`.
- A digit is blank when `en_mask[k]` = 0 or it is suppressed (see Configuration). A blank digit drives `cn`=7'h7F, `dp`=1 and `an`=8'hFF for that slot; no anode is asserted.

## Timing
- Reset values:
  - `an` = 8'hFF, `cn` = 7'h7F, `dp` = 1, `frame` = 0, `pending` = 0.
  - `pcnt` = 0, `idx` = 0, active = 0, pend = 0.
- First `tick` occurs DIV cycles after reset release. Outputs stay dark until the cycle after the first `tick`, which displays slot 1.
- Outputs change only in the cycle after a `tick`; they are registered with 1-cycle latency from `tick`.
- `frame` is high in the cycle after the boundary tick, the same cycle in which the outputs show slot 0 from the new active set.
- Latency from `load` to visible is at most 8·DIV+1 cycles. The new value is first visible on slot 0.
- `rst` asserted mid-frame forces all reset values immediately. Pend content is discarded.
- `load` during `rst` is ignored.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: starting from digit 7 downward, enabled digits with code 0 are blanked until the first nonzero enabled digit is reached.
  - Disabled digits are skipped for this scan; they neither stop nor count as leading zeros.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its decimal point if `dp_mask[k]` = 1; in that case `an` is asserted and `cn` = 7'h7F.
- Not defined: every enabled digit shows its glyph, including leading zeros.

## Test plan
- DIV=4, reset, release, load `data`=32'h7654_3210, `en_mask`=FF, `dp_mask`=00 → after the next `frame`, `an` cycles FE,FD,…,7F every 4 cycles with `cn` = glyphs 0..7; `frame` pulses every 32 cycles.
- DIV=4, `en_mask`=8'h0F, `dp_mask`=8'h04 → slots 4–7 give `an`=FF and `cn`=7F; slot 2 gives `dp`=0.
- DIV=4, load A then load B mid-frame → `pending`=1 and the display keeps the old value; after the boundary it shows B only, and A never appears.
- DIV=4, `load` in the same cycle as the boundary tick → the new value shows on slot 0 the next cycle and `pending` stays 0.
- With `LEADING_ZERO_BLANK_EN`: `data`=32'h0000_0305, `en_mask`=FF → digits 7..3 blank, digit 2 shows 3, digit 1 shows 0, digit 0 shows 5; with `data`=0, only digit 0 lights (glyph 0).
- Assert `rst` mid-frame with `pending`=1 → next cycle gives `an`=FF, `cn`=7F, `pending`=0; after release the display is dark (active=0, `en_mask`=0) until a new load.
